// File: rtl/regfile_wb_queue_pkg.sv
// Shared types and constants for the register-file writeback queue.
// Entries carry a 4-bit destination and a WB_DW-bit value; r15 is the PC.
package regfile_wb_queue_pkg;

  localparam int         WB_DEPTH = 4;
  localparam int         WB_DW    = 32;
  localparam logic [3:0] REG_PC   = 4'd15;

  typedef struct packed {
    logic [3:0]       addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_wb_fifo.sv
// Circular writeback store: up to two pushes and one pop per cycle, count-tracked.
// Zero-latency head view; no internal backpressure, callers size pushes against count.
module wb_fifo
  import regfile_wb_queue_pkg::*;
#(
  parameter  int DEPTH = WB_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    push0_vld,
  input  wb_entry_t               push0_dat,
  input  logic                    push1_vld,
  input  wb_entry_t               push1_dat,
  input  logic                    pop,
  output wb_entry_t [DEPTH-1:0]   slots,
  output logic      [PW-1:0]      head,
  output logic      [CW-1:0]      count
);

  wb_entry_t [DEPTH-1:0] mem_q;
  logic      [PW-1:0]    head_q;
  logic      [PW-1:0]    tail_q;
  logic      [CW-1:0]    count_q;

  logic                  wr0_vld;
  logic                  wr1_vld;
  wb_entry_t             wr0_dat;
  logic                  do_pop;
  logic      [CW-1:0]    n_enq;

  // A lone push1 lands in the tail slot; with both, push0 takes the older slot.
  always_comb begin
    wr0_vld = push0_vld | push1_vld;
    wr1_vld = push0_vld & push1_vld;
    wr0_dat = push0_vld ? push0_dat : push1_dat;
    do_pop  = pop && (count_q != '0);
    n_enq   = CW'(wr0_vld) + CW'(wr1_vld);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_pop) begin
        head_q <= head_q + PW'(1);
      end
      tail_q  <= tail_q + PW'(n_enq);
      count_q <= count_q - CW'(do_pop) + n_enq;
    end
  end

  // Payload storage needs no reset: occupancy is defined solely by count_q.
  always_ff @(posedge CLK) begin
    if (wr0_vld) begin
      mem_q[tail_q] <= wr0_dat;
    end
    if (wr1_vld) begin
      mem_q[tail_q + PW'(1)] <= push1_dat;
    end
  end

  assign slots = mem_q;
  assign head  = head_q;
  assign count = count_q;

endmodule

// File: rtl/regfile_wb_queue.sv
// Queues ALU/load writebacks and drains one per cycle to WE3/A3/WD3, r15 to PCWE/PCWD.
// Head visible the cycle after enqueue; READY derives from registered count only.
module regfile_wb_queue
  import regfile_wb_queue_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int DW    = WB_DW
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     ALU_VALID,
  input  logic [3:0]               ALU_A,
  input  logic [DW-1:0]            ALU_D,
  output logic                     ALU_READY,
  input  logic                     MEM_VALID,
  input  logic [3:0]               MEM_A,
  input  logic [DW-1:0]            MEM_D,
  output logic                     MEM_READY,
  output logic                     WE3,
  output logic [3:0]               A3,
  output logic [DW-1:0]            WD3,
  output logic                     PCWE,
  output logic [DW-1:0]            PCWD,
  input  logic [3:0]               FWD_A,
  output logic                     FWD_HIT,
  output logic [DW-1:0]            FWD_D,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t [DEPTH-1:0] slots;
  logic      [PW-1:0]    head_ptr;
  logic      [CW-1:0]    count;
  logic      [CW-1:0]    free;
  logic                  alu_acc;
  logic                  mem_acc;
  wb_entry_t             alu_ent;
  wb_entry_t             mem_ent;
  wb_entry_t             head_ent;
  logic                  head_vld;
  logic      [PW-1:0]    fwd_idx;

  // A same-cycle pop does not count as free space; MEM yields a slot to ALU.
  always_comb begin
    free      = CW'(DEPTH) - count;
    ALU_READY = (free >= CW'(1));
    MEM_READY = ALU_VALID ? (free >= CW'(2)) : (free >= CW'(1));
    alu_acc   = ALU_VALID & ALU_READY;
    mem_acc   = MEM_VALID & MEM_READY;
    alu_ent   = '{addr: ALU_A, data: WB_DW'(ALU_D)};
    mem_ent   = '{addr: MEM_A, data: WB_DW'(MEM_D)};
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .push0_vld (alu_acc),
    .push0_dat (alu_ent),
    .push1_vld (mem_acc),
    .push1_dat (mem_ent),
    .pop       (head_vld),
    .slots     (slots),
    .head      (head_ptr),
    .count     (count)
  );

  assign head_ent = slots[head_ptr];
  assign head_vld = (count != '0);
  assign COUNT    = count;

  // r15 has no register-file storage, so its writes are steered to the PC.
  always_comb begin
    WE3  = 1'b0;
    A3   = '0;
    WD3  = '0;
    PCWE = 1'b0;
    PCWD = '0;
    if (head_vld) begin
      if (head_ent.addr == REG_PC) begin
        PCWE = 1'b1;
        PCWD = DW'(head_ent.data);
      end else begin
        WE3 = 1'b1;
        A3  = head_ent.addr;
        WD3 = DW'(head_ent.data);
      end
    end
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    FWD_HIT = 1'b0;
    FWD_D   = '0;
    fwd_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_ptr + PW'(i);
      if ((CW'(i) < count) && (slots[fwd_idx].addr == FWD_A)) begin
        FWD_HIT = 1'b1;
        FWD_D   = DW'(slots[fwd_idx].data);
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed table-driven bench for regfile_wb_queue plus an async-reset sequence.
module tb_regfile_wb_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid;
  logic [3:0]  alu_a, mem_a, fwd_a;
  logic [31:0] alu_d, mem_d;
  logic        alu_ready, mem_ready;
  logic        we3, pcwe, fwd_hit;
  logic [3:0]  a3;
  logic [31:0] wd3, pcwd, fwd_d;
  logic [2:0]  count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  regfile_wb_queue #(.DEPTH(4), .DW(32)) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .ALU_VALID (alu_valid),
    .ALU_A     (alu_a),
    .ALU_D     (alu_d),
    .ALU_READY (alu_ready),
    .MEM_VALID (mem_valid),
    .MEM_A     (mem_a),
    .MEM_D     (mem_d),
    .MEM_READY (mem_ready),
    .WE3       (we3),
    .A3        (a3),
    .WD3       (wd3),
    .PCWE      (pcwe),
    .PCWD      (pcwd),
    .FWD_A     (fwd_a),
    .FWD_HIT   (fwd_hit),
    .FWD_D     (fwd_d),
    .COUNT     (count)
  );

  typedef struct {
    logic        alu_v;
    logic [3:0]  alu_a;
    logic [31:0] alu_d;
    logic        mem_v;
    logic [3:0]  mem_a;
    logic [31:0] mem_d;
    logic [3:0]  fa;
    logic        we3;
    logic [3:0]  a3;
    logic [31:0] wd3;
    logic        pcwe;
    logic [31:0] pcwd;
    logic        ardy;
    logic        mrdy;
    logic        hit;
    logic [31:0] fd;
    logic [2:0]  cnt;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [3:0] ma, input logic [31:0] md,
                       input logic [3:0] fa);
    alu_valid = av; alu_a = aa; alu_d = ad;
    mem_valid = mv; mem_a = ma; mem_d = md;
    fwd_a = fa;
  endtask

  initial begin
    // Each row: inputs for the cycle, then outputs expected at mid-cycle.
    //            alu v,a,d          mem v,a,d       fa  we3 a3 wd3      pcwe pcwd    ardy mrdy hit fd     cnt
    vecs[0]  = '{0, 0, 32'h0,     0, 0, 32'h0,    0,  0, 0, 32'h0,    0, 32'h0,   1, 1, 0, 32'h0,   3'd0};
    vecs[1]  = '{1, 3, 32'h11,    0, 0, 32'h0,    0,  0, 0, 32'h0,    0, 32'h0,   1, 1, 0, 32'h0,   3'd0};
    vecs[2]  = '{0, 0, 32'h0,     0, 0, 32'h0,    3,  1, 3, 32'h11,   0, 32'h0,   1, 1, 1, 32'h11,  3'd1};
    vecs[3]  = '{1, 1, 32'hA,     1, 2, 32'hB,    3,  0, 0, 32'h0,    0, 32'h0,   1, 1, 0, 32'h0,   3'd0};
    vecs[4]  = '{0, 0, 32'h0,     0, 0, 32'h0,    2,  1, 1, 32'hA,    0, 32'h0,   1, 1, 1, 32'hB,   3'd2};
    vecs[5]  = '{0, 0, 32'h0,     0, 0, 32'h0,    1,  1, 2, 32'hB,    0, 32'h0,   1, 1, 0, 32'h0,   3'd1};
    vecs[6]  = '{1, 15, 32'h100,  0, 0, 32'h0,    15, 0, 0, 32'h0,    0, 32'h0,   1, 1, 0, 32'h0,   3'd0};
    vecs[7]  = '{0, 0, 32'h0,     0, 0, 32'h0,    15, 0, 0, 32'h0,    1, 32'h100, 1, 1, 1, 32'h100, 3'd1};
    vecs[8]  = '{0, 0, 32'h0,     0, 0, 32'h0,    15, 0, 0, 32'h0,    0, 32'h0,   1, 1, 0, 32'h0,   3'd0};
    vecs[9]  = '{1, 7, 32'h9,     1, 5, 32'h1,    0,  0, 0, 32'h0,    0, 32'h0,   1, 1, 0, 32'h0,   3'd0};
    vecs[10] = '{1, 5, 32'h2,     1, 8, 32'h4,    5,  1, 7, 32'h9,    0, 32'h0,   1, 1, 1, 32'h1,   3'd2};
    vecs[11] = '{1, 9, 32'h55,    1, 10, 32'h66,  5,  1, 5, 32'h1,    0, 32'h0,   1, 0, 1, 32'h2,   3'd3};
    vecs[12] = '{0, 0, 32'h0,     1, 10, 32'h66,  5,  1, 5, 32'h2,    0, 32'h0,   1, 1, 1, 32'h2,   3'd3};
    vecs[13] = '{0, 0, 32'h0,     0, 0, 32'h0,    5,  1, 8, 32'h4,    0, 32'h0,   1, 1, 0, 32'h0,   3'd3};
    vecs[14] = '{0, 0, 32'h0,     0, 0, 32'h0,    10, 1, 9, 32'h55,   0, 32'h0,   1, 1, 1, 32'h66,  3'd2};
    vecs[15] = '{0, 0, 32'h0,     0, 0, 32'h0,    9,  1, 10, 32'h66,  0, 32'h0,   1, 1, 0, 32'h0,   3'd1};
    vecs[16] = '{0, 0, 32'h0,     0, 0, 32'h0,    0,  0, 0, 32'h0,    0, 32'h0,   1, 1, 0, 32'h0,   3'd0};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int v = 0; v < NV; v++) begin
      drive(vecs[v].alu_v, vecs[v].alu_a, vecs[v].alu_d,
            vecs[v].mem_v, vecs[v].mem_a, vecs[v].mem_d, vecs[v].fa);
      @(negedge clk);
      chk($sformatf("v%0d we3", v), {31'b0, we3}, {31'b0, vecs[v].we3});
      chk($sformatf("v%0d pcwe", v), {31'b0, pcwe}, {31'b0, vecs[v].pcwe});
      chk($sformatf("v%0d alu_ready", v), {31'b0, alu_ready}, {31'b0, vecs[v].ardy});
      chk($sformatf("v%0d mem_ready", v), {31'b0, mem_ready}, {31'b0, vecs[v].mrdy});
      chk($sformatf("v%0d count", v), {29'b0, count}, {29'b0, vecs[v].cnt});
      chk($sformatf("v%0d fwd_hit", v), {31'b0, fwd_hit}, {31'b0, vecs[v].hit});
      chk($sformatf("v%0d fwd_d", v), fwd_d, vecs[v].fd);
      if (vecs[v].we3 || vecs[v].cnt == 3'd0) begin
        chk($sformatf("v%0d a3", v), {28'b0, a3}, {28'b0, vecs[v].a3});
        chk($sformatf("v%0d wd3", v), wd3, vecs[v].wd3);
      end
      if (vecs[v].pcwe || vecs[v].cnt == 3'd0) begin
        chk($sformatf("v%0d pcwd", v), pcwd, vecs[v].pcwd);
      end
      @(posedge clk);
      #1;
    end

    // Async reset with three entries pending: outputs clear at once, nothing drains later.
    drive(1, 1, 32'h10, 1, 2, 32'h20, 0);
    @(posedge clk);
    #1 drive(1, 3, 32'h30, 1, 4, 32'h40, 0);
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("pre_reset count", {29'b0, count}, 32'd3);
    chk("pre_reset we3", {31'b0, we3}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("reset we3", {31'b0, we3}, 32'd0);
    chk("reset pcwe", {31'b0, pcwe}, 32'd0);
    chk("reset count", {29'b0, count}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("post_reset c%0d we3", c), {31'b0, we3}, 32'd0);
      chk($sformatf("post_reset c%0d count", c), {29'b0, count}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
